// File: rtl/serv_rf_ram_bridge_pkg.sv
// Shared types and counter landmarks for the serial register-file RAM bridge.
package serv_rf_ram_bridge_pkg;

   typedef enum logic {
      R_IDLE = 1'b0,
      R_RUN  = 1'b1
   } rstate_t;

   localparam logic [5:0] RCNT_READY = 6'd2;
   localparam logic [5:0] RCNT_LAST  = 6'd34;

endpackage

// File: rtl/serv_rf_ram_bridge_wr.sv
// Write-side deserialiser: gathers the two serial write ports into W-bit RAM words.
module serv_rf_ram_bridge_wr #(
   parameter int W   = 8,
   parameter int RW  = 6,
   parameter int AW  = 8,
   parameter int L2W = 3
) (
   input  logic          clk,
   input  logic          i_rst,
   input  logic          i_wreq,
   input  logic [RW-1:0] i_wreg0,
   input  logic [RW-1:0] i_wreg1,
   input  logic          i_wen0,
   input  logic          i_wen1,
   input  logic          i_wdata0,
   input  logic          i_wdata1,
   output logic [AW-1:0] o_waddr,
   output logic [W-1:0]  o_wdata,
   output logic          o_wen
);

   logic [4:0]    wcnt;
   logic [W-2:0]  wsr0;
   logic [W-2:0]  wsr1;
   logic          any_wen;
   logic          word_done;
   logic          pend_vld_p1;
   logic [AW-1:0] pend_addr_p1;
   logic [W-1:0]  pend_data_p1;

   assign any_wen   = i_wen0 | i_wen1;
   assign word_done = any_wen & (&wcnt[L2W-1:0]);

   always_ff @(posedge clk) begin
      if (i_rst) begin
         wcnt        <= '0;
         pend_vld_p1 <= 1'b0;
      end else begin
         if (i_wreq)
            wcnt <= '0;
         else if (any_wen)
            wcnt <= wcnt + 5'd1;
         pend_vld_p1 <= word_done & i_wen1;
      end
   end

   // Stage p1: the port-1 word is parked one cycle so it never competes with port 0
   always_ff @(posedge clk) begin
      if (i_wen0)
         wsr0 <= {i_wdata0, wsr0[W-2:1]};
      if (i_wen1)
         wsr1 <= {i_wdata1, wsr1[W-2:1]};
      if (word_done && i_wen1) begin
         pend_addr_p1 <= AW'({i_wreg1, wcnt} >> L2W);
         pend_data_p1 <= {i_wdata1, wsr1};
      end
   end

   always_comb begin
      o_wen   = 1'b0;
      o_waddr = '0;
      o_wdata = '0;
      if (!i_rst) begin
         if (word_done && i_wen0) begin
            o_wen   = 1'b1;
            o_waddr = AW'({i_wreg0, wcnt} >> L2W);
            o_wdata = {i_wdata0, wsr0};
         end else if (pend_vld_p1) begin
            o_wen   = 1'b1;
            o_waddr = pend_addr_p1;
            o_wdata = pend_data_p1;
         end
      end
   end

endmodule

// File: rtl/serv_rf_ram_bridge.sv
// Bridges the core's bit-serial register file ports to a W-bit dual-port RAM
// with a registered read; read streams are serialised here, writes in _wr.
module serv_rf_ram_bridge
   import serv_rf_ram_bridge_pkg::*;
#(
   parameter int W        = 8,
   parameter int WITH_CSR = 1,
   localparam int L2W     = $clog2(W),
   localparam int RW      = 5 + WITH_CSR,
   localparam int DEPTH   = (32 + 4*WITH_CSR)*32/W,
   localparam int AW      = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          i_rst,
   input  logic          i_rreq,
   input  logic          i_wreq,
   output logic          o_ready,
   input  logic [RW-1:0] i_rreg0,
   input  logic [RW-1:0] i_rreg1,
   output logic          o_rdata0,
   output logic          o_rdata1,
   input  logic [RW-1:0] i_wreg0,
   input  logic [RW-1:0] i_wreg1,
   input  logic          i_wen0,
   input  logic          i_wen1,
   input  logic          i_wdata0,
   input  logic          i_wdata1,
   output logic [AW-1:0] o_waddr,
   output logic [W-1:0]  o_wdata,
   output logic          o_wen,
   output logic [AW-1:0] o_raddr,
   input  logic [W-1:0]  i_rdata
);

   localparam logic [L2W-1:0] LO_ONE = L2W'(1);
   localparam logic [L2W-1:0] LO_TWO = L2W'(2);

   rstate_t      rstate;
   rstate_t      rstate_nxt;
   logic [5:0]   rcnt;
   logic [5:0]   rcnt_nxt;
   logic         run;
   logic         issue;
   logic         wreq_p1;
   logic [W-1:0] hold;
   logic [W-1:0] sr0;
   logic [W-1:0] sr1;

   assign run   = (rstate == R_RUN);
   assign issue = run & ~rcnt[5];

   always_ff @(posedge clk) begin
      if (i_rst) begin
         rstate  <= R_IDLE;
         rcnt    <= '0;
         wreq_p1 <= 1'b0;
      end else begin
         rstate  <= rstate_nxt;
         rcnt    <= rcnt_nxt;
         wreq_p1 <= i_wreq;
      end
   end

   always_comb begin
      rstate_nxt = rstate;
      rcnt_nxt   = rcnt;
      if (rstate == R_RUN) begin
         rcnt_nxt = rcnt + 6'd1;
         if (rcnt == RCNT_LAST)
            rstate_nxt = R_IDLE;
      end
      if (i_rreq) begin
         rcnt_nxt   = '0;
         rstate_nxt = R_RUN;
      end
   end

   // rs1 word is fetched first and parked in hold so both shifters load together
   always_comb begin
      o_raddr = '0;
      if (issue && rcnt[L2W-1:0] == '0)
         o_raddr = AW'({i_rreg0, rcnt[4:0]} >> L2W);
      else if (issue && rcnt[L2W-1:0] == LO_ONE)
         o_raddr = AW'({i_rreg1, rcnt[4:0]} >> L2W);
   end

   always_ff @(posedge clk) begin
      if (issue && rcnt[L2W-1:0] == LO_ONE)
         hold <= i_rdata;
   end

   // Stage p1: shifters present bit k at rcnt==3+k; x0 reads load zero
   always_ff @(posedge clk) begin
      if (i_rst) begin
         sr0 <= '0;
         sr1 <= '0;
      end else if (issue && rcnt[L2W-1:0] == LO_TWO) begin
         sr0 <= (i_rreg0 == '0) ? '0 : hold;
         sr1 <= (i_rreg1 == '0) ? '0 : i_rdata;
      end else begin
         sr0 <= sr0 >> 1;
         sr1 <= sr1 >> 1;
      end
   end

   assign o_rdata0 = sr0[0];
   assign o_rdata1 = sr1[0];
   assign o_ready  = (run && rcnt == RCNT_READY) || (wreq_p1 && !run);

   serv_rf_ram_bridge_wr #(
      .W   (W),
      .RW  (RW),
      .AW  (AW),
      .L2W (L2W)
   ) u_wr (
      .clk      (clk),
      .i_rst    (i_rst),
      .i_wreq   (i_wreq),
      .i_wreg0  (i_wreg0),
      .i_wreg1  (i_wreg1),
      .i_wen0   (i_wen0),
      .i_wen1   (i_wen1),
      .i_wdata0 (i_wdata0),
      .i_wdata1 (i_wdata1),
      .o_waddr  (o_waddr),
      .o_wdata  (o_wdata),
      .o_wen    (o_wen)
   );

endmodule
